// File: rtl/cla_seq_pkg.sv
// cla_seq_pkg
// Shared definitions for the multi-word CLA sequencer:
//   state_e     - controller states (IDLE, RUN, DONE)
//   CLA_WORD_W  - width of the single shared carry-lookahead adder
package cla_seq_pkg;

    localparam int CLA_WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : cla_seq_pkg

// File: rtl/cla_16bits.sv
// cla_16bits
// Two-level 16-bit carry-lookahead adder: S = A + B + Cin.
// Four 4-bit lookahead groups feed a second-level lookahead unit that
// produces the group carry-ins and the final carry-out.
// Ports:
//   A, B  in  16  addends
//   Cin   in  1   carry-in
//   S     out 16  sum
//   Cout  out 1   carry-out
module cla_16bits (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] g;      // bit generate
    logic [15:0] p;      // bit propagate
    logic [15:0] c;      // carry into each bit
    logic [3:0]  grp_g;  // group generate
    logic [3:0]  grp_p;  // group propagate
    logic [3:0]  grp_c;  // carry into each group

    assign g = A & B;
    assign p = A ^ B;

    // Second-level lookahead over the four groups.
    assign grp_c[0] = Cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & Cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & Cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & Cin);
    assign Cout     = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & Cin);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_group
            logic [3:0] gg;
            logic [3:0] pp;
            logic       c0;

            assign gg = g[gi*4 +: 4];
            assign pp = p[gi*4 +: 4];
            assign c0 = grp_c[gi];

            // First-level lookahead: every carry inside the group is a
            // flat sum of products of the group carry-in.
            assign c[gi*4 + 0] = c0;
            assign c[gi*4 + 1] = gg[0] | (pp[0] & c0);
            assign c[gi*4 + 2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c0);
            assign c[gi*4 + 3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                               | (pp[2] & pp[1] & pp[0] & c0);

            assign grp_g[gi] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                             | (pp[3] & pp[2] & pp[1] & gg[0]);
            assign grp_p[gi] = &pp;
        end
    endgenerate

    assign S = p ^ c;

endmodule : cla_16bits

// File: rtl/cla_multiword_seq.sv
// cla_multiword_seq
// Performs WORD_W*NUM_WORDS-bit add/subtract by reusing one 16-bit CLA,
// one word per cycle, least-significant word first, with the carry chained
// through carry_q. Subtraction is A + ~B + 1: B is inverted at capture and
// the initial carry forced to 1.
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   in_valid/in_ready request handshake (in_ready only in IDLE, not in reset)
//   op_a, op_b        operands
//   sub, cin          1 = A-B (cin ignored), 0 = A+B+cin
//   out_valid/out_ready result handshake; outputs held stable while waiting
//   result            sum/difference
//   cout              final carry (for sub: 1 = no borrow)
//   overflow          signed two's-complement overflow
//   busy              high while an operation is in RUN or DONE
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int NUM_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WORD_W*NUM_WORDS-1:0]   op_a,
    input  logic [WORD_W*NUM_WORDS-1:0]   op_b,
    input  logic                          sub,
    input  logic                          cin,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WORD_W*NUM_WORDS-1:0]   result,
    output logic                          cout,
    output logic                          overflow,
    output logic                          busy
);

    localparam int TOTAL_W = WORD_W * NUM_WORDS;
    localparam int IDX_W   = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

    generate
        if (WORD_W != CLA_WORD_W) begin : g_bad_word_w
            $error("cla_multiword_seq: WORD_W must equal the CLA width (16)");
        end
        if (NUM_WORDS < 2) begin : g_bad_num_words
            $error("cla_multiword_seq: NUM_WORDS must be at least 2");
        end
    endgenerate

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic                carry_q;
    logic [TOTAL_W-1:0]  a_q;
    logic [TOTAL_W-1:0]  b_q;
    logic [WORD_W-1:0]   result_q [NUM_WORDS];
    logic                cout_q;
    logic                overflow_q;
    logic                out_valid_q;

    logic                accept_d;
    logic                last_word_d;
    logic [WORD_W-1:0]   a_words_d [NUM_WORDS];
    logic [WORD_W-1:0]   b_words_d [NUM_WORDS];
    logic [WORD_W-1:0]   word_a_d;
    logic [WORD_W-1:0]   word_b_d;
    logic [WORD_W-1:0]   sum_d;
    logic                carry_out_d;
    logic                overflow_d;

    assign in_ready    = (state_q == IDLE) && !rst;
    assign busy        = (state_q != IDLE);
    assign accept_d    = in_valid && in_ready;
    assign last_word_d = (idx_q == LAST_IDX);

    // Word views of the captured operands and flattened result output.
    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_words
            assign a_words_d[gi]             = a_q[gi*WORD_W +: WORD_W];
            assign b_words_d[gi]             = b_q[gi*WORD_W +: WORD_W];
            assign result[gi*WORD_W +: WORD_W] = result_q[gi];
        end
    endgenerate

    assign word_a_d = a_words_d[idx_q];
    assign word_b_d = b_words_d[idx_q];

    cla_16bits u_cla (
        .A    (word_a_d),
        .B    (word_b_d),
        .Cin  (carry_q),
        .S    (sum_d),
        .Cout (carry_out_d)
    );

    // Signed overflow uses the stored (already inverted for sub) B sign.
    assign overflow_d = (a_q[TOTAL_W-1] == b_q[TOTAL_W-1])
                     && (sum_d[WORD_W-1] != a_q[TOTAL_W-1]);

    // Operand capture needs no reset: the registers are only read in RUN,
    // which is always entered through a capture.
    always_ff @(posedge clk) begin
        if (accept_d) begin
            a_q <= op_a;
            b_q <= sub ? ~op_b : op_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NUM_WORDS; i++) begin
                result_q[i] <= '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        carry_q <= sub ? 1'b1 : cin;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    result_q[idx_q] <= sum_d;
                    carry_q         <= carry_out_d;
                    if (last_word_d) begin
                        cout_q      <= carry_out_d;
                        overflow_q  <= overflow_d;
                        out_valid_q <= 1'b1;
                        idx_q       <= '0;   // keep idx within range in DONE
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign cout      = cout_q;
    assign overflow  = overflow_q;

endmodule : cla_multiword_seq
